// File: rtl/iram_boot_loader.sv
// Boot loader: turns a framed UART byte stream into instruction RAM word writes.
// Releases cpu_hold only after a complete image with a matching checksum.
module iram_boot_loader #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned AW      = 10,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        iram_we,
    output logic [31:0] iram_waddr,
    output logic [31:0] iram_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLen0 = 3'd1;
    localparam logic [2:0] StLen1 = 3'd2;
    localparam logic [2:0] StData = 3'd3;
    localparam logic [2:0] StCsum = 3'd4;
    localparam logic [2:0] StDone = 3'd5;
    localparam logic [2:0] StErr  = 3'd6;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [1:0]    byte_q, byte_d;
    logic [AW:0]   word_q, word_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          in_frame;
    logic [15:0]   len_full;

    assign in_frame = (state_q == StLen0) || (state_q == StLen1) ||
                      (state_q == StData) || (state_q == StCsum);
    assign len_full = {rx_data, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        byte_d  = byte_q;
        word_d  = word_q;
        shreg_d = shreg_q;
        tcnt_d  = tcnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        if (rx_valid) begin
            tcnt_d = '0;
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (rx_data == SYNC) begin
                        state_d = StLen0;
                        csum_d  = '0;
                        byte_d  = '0;
                        word_d  = '0;
                        waddr_d = '0;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                StLen0: begin
                    len_d[7:0] = rx_data;
                    csum_d     = csum_q + rx_data;
                    state_d    = StLen1;
                end
                StLen1: begin
                    len_d[15:8] = rx_data;
                    csum_d      = csum_q + rx_data;
                    if (len_full > 16'(DEPTH)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    csum_d = csum_q + rx_data;
                    byte_d = byte_q + 1'b1;
                    if (byte_q == 2'd0) begin
                        shreg_d[7:0] = rx_data;
                    end else if (byte_q == 2'd1) begin
                        shreg_d[15:8] = rx_data;
                    end else if (byte_q == 2'd2) begin
                        shreg_d[23:16] = rx_data;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = {rx_data, shreg_q};
                        waddr_d = word_q[AW-1:0];
                        word_d  = word_q + 1'b1;
                        // Entering CSUM here lets the checksum byte follow immediately.
                        if (16'(word_q) + 16'd1 == len_q) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (rx_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (in_frame) begin
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                state_d = StErr;
                err_d   = 1'b1;
                hold_d  = 1'b1;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            csum_q  <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            shreg_q <= '0;
            tcnt_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            shreg_q <= shreg_d;
            tcnt_q  <= tcnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign iram_we    = we_q;
    assign iram_waddr = {{(32 - AW){1'b0}}, waddr_q};
    assign iram_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
